// File: rtl/bus_resp_pkg.sv
// Shared types and defaults for the 68k bus responder: FSM states, select codes,
// default wait/timeout values and the select priority decoder.
package bus_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ROM  = 2'd1,
        SEL_RAM  = 2'd2,
        SEL_IO   = 2'd3
    } sel_e;

    localparam int DEF_ROM_WAIT     = 2;
    localparam int DEF_RAM_WAIT     = 0;
    localparam int DEF_IO_WAIT      = 4;
    localparam int DEF_BERR_TIMEOUT = 64;
    localparam int DEF_CNT_W        = 8;

    // ROM wins over RAM, RAM wins over IO.
    function automatic sel_e decode_sel(input logic rom_cs_n,
                                        input logic ram_cs_n,
                                        input logic io_cs_n);
        sel_e sel;
        if (!rom_cs_n) begin
            sel = SEL_ROM;
        end else if (!ram_cs_n) begin
            sel = SEL_RAM;
        end else if (!io_cs_n) begin
            sel = SEL_IO;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_resp_if.sv
// CPU-side bus signals seen by the responder: strobe, decoded selects, IO ready
// and the DTACK/BERR termination outputs.
interface bus_resp_if;
    logic i_AS_n;
    logic i_ROM_CS_n;
    logic i_RAM_CS_n;
    logic i_IO_CS_n;
    logic i_IO_READY;
    logic o_DTACK_n;
    logic o_BERR_n;
    logic o_TIMEOUT;

    modport master (
        output i_AS_n, i_ROM_CS_n, i_RAM_CS_n, i_IO_CS_n, i_IO_READY,
        input  o_DTACK_n, o_BERR_n, o_TIMEOUT
    );

    modport slave (
        input  i_AS_n, i_ROM_CS_n, i_RAM_CS_n, i_IO_CS_n, i_IO_READY,
        output o_DTACK_n, o_BERR_n, o_TIMEOUT
    );
endinterface

// File: rtl/bus_resp_watchdog.sv
// Saturating bus-cycle timeout counter. o_expired flags that the edge now being
// evaluated is the one on which the count reaches TIMEOUT.
module bus_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_start,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: the start edge counts as edge 1, then one per running edge.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = ZERO;
        end else if (i_start) begin
            cnt_d = ONE;
        end else if (i_run && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
        o_expired = (i_start || i_run) && !i_clear && (cnt_d >= LIMIT);
    end

    // Counter register.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bus_responder.sv
// 68k bus cycle terminator: per-select wait states then DTACK, watchdog BERR for
// cycles nobody terminates, abort when AS_n rises early.
module bus_responder
    import bus_resp_pkg::*;
#(
    parameter int ROM_WAIT     = DEF_ROM_WAIT,
    parameter int RAM_WAIT     = DEF_RAM_WAIT,
    parameter int IO_WAIT      = DEF_IO_WAIT,
    parameter int BERR_TIMEOUT = DEF_BERR_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       i_CLK,
    input  logic       i_RESET_n,
    bus_resp_if.slave  bus
);
    localparam logic [CNT_W-1:0] ROM_W = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_W  = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dtack_n_q, dtack_n_d;
    logic             berr_n_q, berr_n_d;
    logic             timeout_q, timeout_d;

    sel_e             sel_now_s;
    logic [CNT_W-1:0] load_s;
    logic             ack_idle_s;
    logic             ack_wait_s;
    logic             wd_start_s;
    logic             wd_run_s;
    logic             wd_clear_s;
    logic             wd_expired_s;

    bus_watchdog #(
        .TIMEOUT (BERR_TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .i_start   (wd_start_s),
        .i_run     (wd_run_s),
        .i_clear   (wd_clear_s),
        .o_expired (wd_expired_s)
    );

    // Select decode and wait-count load value for a cycle starting this edge.
    always_comb begin
        sel_now_s = decode_sel(bus.i_ROM_CS_n, bus.i_RAM_CS_n, bus.i_IO_CS_n);
        case (sel_now_s)
            SEL_ROM: load_s = ROM_W;
            SEL_RAM: load_s = RAM_W;
            SEL_IO:  load_s = IO_W;
            default: load_s = ZERO;
        endcase
        // A zero wait acknowledges on edge 1 itself; IO still needs READY.
        ack_idle_s = (sel_now_s != SEL_NONE) && (load_s == ZERO) &&
                     ((sel_now_s != SEL_IO) || bus.i_IO_READY);
        // The count reaches zero on this edge (or already sits there).
        ack_wait_s = (sel_q != SEL_NONE) && (cnt_q <= ONE) &&
                     ((sel_q != SEL_IO) || bus.i_IO_READY);
    end

    // Next-state logic; DTACK is checked before the watchdog so it wins a tie.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        wd_start_s = 1'b0;
        wd_run_s   = 1'b0;
        wd_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.i_AS_n) begin
                    wd_start_s = 1'b1;
                    sel_d      = sel_now_s;
                    cnt_d      = load_s;
                    if (ack_idle_s) begin
                        state_d = ST_ACK;
                    end else if (wd_expired_s) begin
                        state_d = ST_BERR;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    wd_clear_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.i_AS_n) begin
                    state_d    = ST_IDLE;
                    wd_clear_s = 1'b1;
                end else begin
                    wd_run_s = 1'b1;
                    cnt_d    = (cnt_q == ZERO) ? ZERO : (cnt_q - ONE);
                    if (ack_wait_s) begin
                        state_d = ST_ACK;
                    end else if (wd_expired_s) begin
                        state_d = ST_BERR;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_ACK, ST_BERR: begin
                if (bus.i_AS_n) begin
                    state_d    = ST_IDLE;
                    wd_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wd_clear_s = 1'b1;
            end
        endcase
        dtack_n_d = (state_d != ST_ACK);
        berr_n_d  = (state_d != ST_BERR);
        timeout_d = (state_d == ST_BERR) && (state_q != ST_BERR);
    end

    // State, cycle context and registered bus outputs.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_NONE;
            cnt_q     <= ZERO;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_DTACK_n = dtack_n_q;
    assign bus.o_BERR_n  = berr_n_q;
    assign bus.o_TIMEOUT = timeout_q;
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: default instance plus one with IO_WAIT set
// one below the timeout to exercise the DTACK/BERR collision.
module tb_bus_responder;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bus_resp_if bus   ();
    bus_resp_if bus_c ();

    bus_responder dut (
        .i_CLK     (clk),
        .i_RESET_n (rst_n),
        .bus       (bus)
    );

    bus_responder #(.IO_WAIT(63)) dut_c (
        .i_CLK     (clk),
        .i_RESET_n (rst_n),
        .bus       (bus_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        bus.i_AS_n     = 1'b1;
        bus.i_ROM_CS_n = 1'b1;
        bus.i_RAM_CS_n = 1'b1;
        bus.i_IO_CS_n  = 1'b1;
        bus.i_IO_READY = 1'b0;
        bus_c.i_AS_n     = 1'b1;
        bus_c.i_ROM_CS_n = 1'b1;
        bus_c.i_RAM_CS_n = 1'b1;
        bus_c.i_IO_CS_n  = 1'b1;
        bus_c.i_IO_READY = 1'b0;
    endtask

    initial begin
        logic bad_a;
        logic bad_b;
        rst_n = 1'b0;
        release_bus();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dtack", bus.o_DTACK_n, 1'b1);
        check_eq("rst_berr", bus.o_BERR_n, 1'b1);
        check_eq("rst_timeout", bus.o_TIMEOUT, 1'b0);
        rst_n = 1'b1;
        step();
        step();

        // RAM, zero wait: DTACK after edge 1, released one edge after AS_n rises.
        bus.i_AS_n = 1'b0; bus.i_RAM_CS_n = 1'b0;
        step();
        check_eq("ram_dtack", bus.o_DTACK_n, 1'b0);
        check_eq("ram_berr", bus.o_BERR_n, 1'b1);
        release_bus();
        step();
        check_eq("ram_release", bus.o_DTACK_n, 1'b1);

        // ROM, two waits; select changes after edge 1 must be ignored.
        bus.i_AS_n = 1'b0; bus.i_ROM_CS_n = 1'b0;
        step();
        check_eq("rom_e1", bus.o_DTACK_n, 1'b1);
        bus.i_ROM_CS_n = 1'b1; bus.i_RAM_CS_n = 1'b0;
        step();
        check_eq("rom_e2", bus.o_DTACK_n, 1'b1);
        step();
        check_eq("rom_e3", bus.o_DTACK_n, 1'b0);
        check_eq("rom_berr", bus.o_BERR_n, 1'b1);
        release_bus();
        step();
        check_eq("rom_release", bus.o_DTACK_n, 1'b1);

        // IO, READY first sampled high on edge 10.
        bus.i_AS_n = 1'b0; bus.i_IO_CS_n = 1'b0;
        bad_a = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (bus.o_DTACK_n !== 1'b1) bad_a = 1'b1;
        end
        check_eq("io_early_dtack", bad_a, 1'b0);
        bus.i_IO_READY = 1'b1;
        step();
        check_eq("io_e10_dtack", bus.o_DTACK_n, 1'b0);
        check_eq("io_berr", bus.o_BERR_n, 1'b1);
        release_bus();
        step();

        // No select: BERR after edge 64 with a single TIMEOUT pulse.
        bus.i_AS_n = 1'b0;
        bad_a = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            step();
            if (bus.o_BERR_n !== 1'b1 || bus.o_TIMEOUT !== 1'b0 || bus.o_DTACK_n !== 1'b1) bad_a = 1'b1;
        end
        check_eq("nosel_early", bad_a, 1'b0);
        step();
        check_eq("nosel_berr", bus.o_BERR_n, 1'b0);
        check_eq("nosel_pulse", bus.o_TIMEOUT, 1'b1);
        check_eq("nosel_dtack", bus.o_DTACK_n, 1'b1);
        step();
        check_eq("nosel_hold", bus.o_BERR_n, 1'b0);
        check_eq("nosel_pulse_end", bus.o_TIMEOUT, 1'b0);
        release_bus();
        step();
        check_eq("nosel_release_berr", bus.o_BERR_n, 1'b1);
        check_eq("nosel_release_dtack", bus.o_DTACK_n, 1'b1);

        // Abort during ROM wait, then a normal RAM cycle.
        bus.i_AS_n = 1'b0; bus.i_ROM_CS_n = 1'b0;
        step();
        release_bus();
        bad_a = 1'b0;
        for (int e = 2; e <= 5; e++) begin
            step();
            if (bus.o_DTACK_n !== 1'b1 || bus.o_BERR_n !== 1'b1) bad_a = 1'b1;
        end
        check_eq("abort_quiet", bad_a, 1'b0);
        bus.i_AS_n = 1'b0; bus.i_RAM_CS_n = 1'b0;
        step();
        check_eq("after_abort_dtack", bus.o_DTACK_n, 1'b0);

        // Back-to-back with AS_n high for a single clock.
        bus.i_AS_n = 1'b1;
        step();
        check_eq("b2b_gap", bus.o_DTACK_n, 1'b1);
        bus.i_AS_n = 1'b0;
        step();
        check_eq("b2b_second", bus.o_DTACK_n, 1'b0);

        // Asynchronous reset while DTACK is asserted.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_dtack", bus.o_DTACK_n, 1'b1);
        check_eq("rst_mid_berr", bus.o_BERR_n, 1'b1);
        release_bus();
        #1 rst_n = 1'b1;
        step();
        check_eq("rst_after", bus.o_DTACK_n, 1'b1);

        // Collision: DTACK and timeout on edge 64, DTACK wins.
        bus_c.i_AS_n = 1'b0; bus_c.i_IO_CS_n = 1'b0; bus_c.i_IO_READY = 1'b1;
        bad_a = 1'b0;
        bad_b = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            step();
            if (bus_c.o_DTACK_n !== 1'b1) bad_a = 1'b1;
            if (bus_c.o_BERR_n !== 1'b1) bad_b = 1'b1;
        end
        check_eq("coll_early_dtack", bad_a, 1'b0);
        check_eq("coll_early_berr", bad_b, 1'b0);
        step();
        check_eq("coll_dtack", bus_c.o_DTACK_n, 1'b0);
        check_eq("coll_berr", bus_c.o_BERR_n, 1'b1);
        check_eq("coll_timeout", bus_c.o_TIMEOUT, 1'b0);
        step();
        check_eq("coll_hold_berr", bus_c.o_BERR_n, 1'b1);
        release_bus();
        step();
        check_eq("coll_release", bus_c.o_DTACK_n, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
